// File: rtl/note_lane_renderer.sv
`default_nettype none
// ============================================================================
// Module  : note_lane_renderer
// Scrolling note lane with a ready/valid push port, exit reporting and a
// row-major pixel scan-out of a frozen lane snapshot.
// Rev     : 1.0
// ============================================================================
module note_lane_renderer #(
  parameter int COLS   = 64,
  parameter int NOTE_W = 7,
  parameter int NOTE_H = 7,
  parameter int SLOTS  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    note_valid,
  input  logic [1:0]              note_type,
  output logic                    note_ready,
  input  logic                    scroll_tick,
  output logic                    exit_valid,
  output logic [1:0]              exit_type,
  input  logic                    frame_start,
  output logic                    busy,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [$clog2(COLS)-1:0] pix_x,
  output logic [2:0]              pix_y,
  output logic [2:0]              pix_rgb,
  output logic                    frame_done
);

  localparam int XW = $clog2(COLS);
  localparam int OW = $clog2(NOTE_W);
  localparam int SW = $clog2(SLOTS);

  localparam logic [XW-1:0] c_X_LAST   = XW'(COLS - 1);
  localparam logic [OW-1:0] c_C_LAST   = OW'(NOTE_W - 1);
  localparam logic [OW-1:0] c_CTR      = OW'(NOTE_W / 2);
  localparam logic [2:0]    c_Y_LAST   = 3'(NOTE_H - 1);
  localparam logic [1:0]    c_EMPTY    = 2'b00;
  localparam logic [1:0]    c_RED      = 2'b01;
  localparam logic [1:0]    c_RSVD     = 2'b11;
  localparam logic [2:0]    c_RGB_RING = 3'b111;
  localparam logic [2:0]    c_RGB_RED  = 3'b100;
  localparam logic [2:0]    c_RGB_BLUE = 3'b011;
  localparam logic [2:0]    c_RGB_OFF  = 3'b000;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SCAN = 1'b1;

  // Live lane state
  logic [1:0]    r_slot [SLOTS];
  logic [OW-1:0] r_offset;
  logic [1:0]    r_stage_type;
  logic          r_stage_full;
  logic          r_exit_valid;
  logic [1:0]    r_exit_type;

  logic          w_push;
  logic          w_shift;
  logic [1:0]    w_note_clean;

  assign note_ready   = !rst && !r_stage_full;
  assign w_push       = note_valid && note_ready;
  assign w_shift      = scroll_tick && (r_offset == c_C_LAST);
  assign w_note_clean = (note_type == c_RSVD) ? c_EMPTY : note_type;

  // A push in the same edge as a shift lands after the shift has drained staging.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SLOTS; k++) r_slot[k] <= c_EMPTY;
      r_offset     <= '0;
      r_stage_type <= c_EMPTY;
      r_stage_full <= 1'b0;
      r_exit_valid <= 1'b0;
      r_exit_type  <= c_EMPTY;
    end else begin
      r_exit_valid <= 1'b0;
      if (scroll_tick) begin
        if (w_shift) begin
          r_offset <= '0;
          for (int k = 0; k < SLOTS - 1; k++) r_slot[k] <= r_slot[k+1];
          r_slot[SLOTS-1] <= r_stage_full ? r_stage_type : c_EMPTY;
          r_stage_type    <= c_EMPTY;
          r_stage_full    <= 1'b0;
          r_exit_valid    <= 1'b1;
          r_exit_type     <= r_slot[0];
        end else begin
          r_offset <= r_offset + OW'(1);
        end
      end
      if (w_push) begin
        r_stage_type <= w_note_clean;
        r_stage_full <= 1'b1;
      end
    end
  end

  assign exit_valid = r_exit_valid;
  assign exit_type  = r_exit_type;

  // Frame scan state
  logic [0:0]    r_state;
  logic [1:0]    r_snap [SLOTS];
  logic [OW-1:0] r_snap_off;
  logic [XW-1:0] r_x;
  logic [2:0]    r_y;
  logic [SW-1:0] r_sidx;
  logic [OW-1:0] r_col;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      for (int k = 0; k < SLOTS; k++) r_snap[k] <= c_EMPTY;
      r_snap_off <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_sidx     <= '0;
      r_col      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (frame_start) begin
            for (int k = 0; k < SLOTS; k++) r_snap[k] <= r_slot[k];
            r_snap_off <= r_offset;
            r_x        <= '0;
            r_y        <= '0;
            r_sidx     <= '0;
            r_col      <= r_offset;
            r_state    <= c_SCAN;
          end
        end
        c_SCAN: begin
          if (pix_ready) begin
            if (r_x == c_X_LAST) begin
              // Each row restarts at slot 0, sprite column = frozen offset.
              r_x    <= '0;
              r_sidx <= '0;
              r_col  <= r_snap_off;
              if (r_y == c_Y_LAST) begin
                r_y     <= '0;
                r_state <= c_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_y <= r_y + 3'd1;
              end
            end else begin
              r_x <= r_x + XW'(1);
              if (r_col == c_C_LAST) begin
                r_col  <= '0;
                r_sidx <= r_sidx + SW'(1);
              end else begin
                r_col <= r_col + OW'(1);
              end
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Sprite lookup for the current pixel
  logic [1:0]    w_type;
  logic [OW-1:0] w_d;
  logic          w_ring;
  logic          w_fill;
  logic [2:0]    w_rgb;

  always_comb begin
    w_type = r_snap[r_sidx];
    w_d    = (r_col >= c_CTR) ? (r_col - c_CTR) : (c_CTR - r_col);
    w_ring = 1'b0;
    w_fill = 1'b0;
    case (r_y)
      3'd0, 3'd6: w_ring = (w_d <= OW'(1));
      3'd1, 3'd5: begin
        w_ring = (w_d == OW'(2));
        w_fill = (w_d <= OW'(1));
      end
      default: begin
        w_ring = (w_d == c_CTR);
        w_fill = (w_d < c_CTR);
      end
    endcase
    w_rgb = c_RGB_OFF;
    if ((r_state == c_SCAN) && (w_type != c_EMPTY)) begin
      if (w_ring)      w_rgb = c_RGB_RING;
      else if (w_fill) w_rgb = (w_type == c_RED) ? c_RGB_RED : c_RGB_BLUE;
    end
  end

  assign busy       = (r_state == c_SCAN);
  assign pix_valid  = (r_state == c_SCAN);
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign pix_rgb    = w_rgb;
  assign frame_done = r_done;

endmodule
`default_nettype wire
